// File: rtl/sum_range_processor.sv
// ---------------------------------------------------------------------------
// sum_range_processor
//
// Dedicated processor that sums the arithmetic series
//   first + (first+step) + ... up to and including the last term <= last.
// A control FSM drives an index register (i), an accumulator (sum) and an
// output register (out/ovf). A run is requested with start and reported with
// a one-cycle done pulse.
//
// Parameters:
//   WIDTH      width of first/last/step (index register is WIDTH+1 bits)
//   ACC_WIDTH  width of the accumulator and of out (>= WIDTH)
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous, active-low reset
//   start  in   request a run; only sampled in IDLE
//   first  in   first term (unsigned)
//   last   in   inclusive upper bound (unsigned)
//   step   in   increment (unsigned); 0 behaves as 1
//   busy   out  high whenever the FSM is not in IDLE
//   done   out  one-cycle pulse while in DONE
//   out    out  result of the last completed run
//   ovf    out  last completed run carried out of ACC_WIDTH
//
// Handshake: start is a request that is accepted in the cycle it is seen
// high while busy=0; first/last/step are captured in that same cycle and are
// don't-care afterwards. done pulses for one cycle when out/ovf carry the new
// result; start seen while busy=1 (including the DONE cycle) is dropped.
//
// Build option (macro SUM_RANGE_SAT_EN):
//   defined   - on accumulator carry, sum clamps to all-ones for the rest of
//               the run (ovf still set)
//   undefined - sum wraps modulo 2^ACC_WIDTH (ovf set)
//
// The current FSM state is held in the signal named state.
// ---------------------------------------------------------------------------
module sum_range_processor #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     first,
  input  logic [WIDTH-1:0]     last,
  input  logic [WIDTH-1:0]     step,
  output logic                 busy,
  output logic                 done,
  output logic [ACC_WIDTH-1:0] out,
  output logic                 ovf
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    CHECK = 3'd2,
    ADD   = 3'd3,
    INC   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     first_q;
  logic [WIDTH-1:0]     last_q;
  logic [WIDTH-1:0]     step_q;
  // One extra bit so i+step can never wrap back below last.
  logic [WIDTH:0]       i;
  logic [ACC_WIDTH-1:0] sum;
  logic                 ovf_run;

  // Accumulator add with carry. In ADD, i <= last < 2^WIDTH, so only the low
  // WIDTH bits of i are significant.
  logic [ACC_WIDTH:0]   add_full;
  logic                 add_carry;

  always_comb begin
    add_full  = {1'b0, sum} + {{(ACC_WIDTH - WIDTH + 1){1'b0}}, i[WIDTH-1:0]};
    add_carry = add_full[ACC_WIDTH];
  end

  // Decoded from state only, so no input-to-output path exists.
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      first_q <= '0;
      last_q  <= '0;
      step_q  <= '0;
      i       <= '0;
      sum     <= '0;
      ovf_run <= 1'b0;
      out     <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            first_q <= first;
            last_q  <= last;
            step_q  <= (step == '0) ? WIDTH'(1) : step;
            state   <= INIT;
          end
        end

        INIT: begin
          sum     <= '0;
          i       <= {1'b0, first_q};
          ovf_run <= 1'b0;
          state   <= CHECK;
        end

        CHECK: begin
          if (i <= {1'b0, last_q}) begin
            state <= ADD;
          end else begin
            out   <= sum;
            ovf   <= ovf_run;
            state <= DONE;
          end
        end

        ADD: begin
          ovf_run <= ovf_run | add_carry;
`ifdef SUM_RANGE_SAT_EN
          // Once clamped, stay clamped for the remainder of the run.
          if (add_carry || ovf_run) begin
            sum <= '1;
          end else begin
            sum <= add_full[ACC_WIDTH-1:0];
          end
`else
          sum <= add_full[ACC_WIDTH-1:0];
`endif
          state <= INC;
        end

        INC: begin
          i     <= i + {1'b0, step_q};
          state <= CHECK;
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
